amns_operand_feeder: RTL

Operand staging buffer sitting directly upstream of the AMNS polynomial FIOS multiplier array. It accepts the B and M operands slice by slice over a valid/ready load port and holds them in two S-deep slice buffers. It then issues the multiplier start pulse and presents one N-word slice of B and one of M, advancing each independently whenever the array requests a shift. A slice is one WORD_WIDTH word per coefficient, i.e. word j of every coefficient.

---
 rtl/amns_pkg.sv | 20 ++
 rtl/amns_operand_feeder_if.sv | 28 ++
 rtl/amns_slice_buffer.sv | 48 ++++
 rtl/amns_operand_feeder.sv | 95 +++++++++
 4 files changed

// File: rtl/amns_pkg.sv
// Shared types and default geometry for the AMNS operand feeder and its slice buffers.
package amns_pkg;

    localparam int WORD_WIDTH = 17;
    localparam int N          = 5;
    localparam int S          = 4;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL,
        RUN
    } feeder_state_t;

    // Pointers and the write counter must be able to hold S itself, the "exhausted" value.
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/amns_operand_feeder_if.sv
// Load, launch and slice-delivery signals between the feeder and its producer/multiplier.
interface amns_operand_feeder_if #(
    parameter int WORD_WIDTH = amns_pkg::WORD_WIDTH,
    parameter int N          = amns_pkg::N
);
    logic                    load_valid_i;
    logic                    load_ready_o;
    logic [N*WORD_WIDTH-1:0] load_B_i;
    logic [N*WORD_WIDTH-1:0] load_M_i;
    logic                    full_o;
    logic                    go_i;
    logic                    start_o;
    logic                    B_shift_i;
    logic                    M_shift_i;
    logic [N*WORD_WIDTH-1:0] B_dout_o;
    logic [N*WORD_WIDTH-1:0] M_dout_o;
    logic                    done_o;

    modport slave (
        input  load_valid_i, load_B_i, load_M_i, go_i, B_shift_i, M_shift_i,
        output load_ready_o, full_o, start_o, B_dout_o, M_dout_o, done_o
    );

    modport master (
        output load_valid_i, load_B_i, load_M_i, go_i, B_shift_i, M_shift_i,
        input  load_ready_o, full_o, start_o, B_dout_o, M_dout_o, done_o
    );
endinterface

// File: rtl/amns_slice_buffer.sv
// S-deep slice store with a write port and an independent read pointer feeding a registered,
// zero-on-exhaust output slice.
module amns_slice_buffer #(
    parameter int WIDTH = 85,
    parameter int S     = 4,
    parameter int PW    = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             launch,
    input  logic             shift,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             exhausted
);
    localparam int AW = (S > 1) ? $clog2(S) : 1;

    logic [WIDTH-1:0] mem [S];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_next;

    assign ptr_next  = ptr + PW'(1);
    assign exhausted = (ptr == PW'(S));

    // NOTE: the slice array has no reset; contents are only ever read after being written by a fill.
    always_ff @(posedge clock_i) begin
        if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr  <= '0;
            dout <= '0;
        end else if (launch) begin
            ptr  <= '0;
            dout <= mem[0];
        end else if (flush) begin
            dout <= '0;
        end else if (shift && !exhausted) begin
            ptr  <= ptr_next;
            dout <= (ptr_next == PW'(S)) ? '0 : mem[ptr_next[AW-1:0]];
        end
    end
endmodule

// File: rtl/amns_operand_feeder.sv
// Operand staging buffer for the AMNS FIOS multiplier: fills B/M slice buffers, launches the
// array, then streams slices on demand until both operands are consumed.
module amns_operand_feeder
    import amns_pkg::*;
#(
    parameter int WORD_WIDTH = amns_pkg::WORD_WIDTH,
    parameter int N          = amns_pkg::N,
    parameter int S          = amns_pkg::S
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    amns_operand_feeder_if.slave  bus
);
    localparam int PW = ptr_width(S);
    localparam int DW = N * WORD_WIDTH;

    feeder_state_t state, state_next;
    logic [PW-1:0] wr_cnt;
    logic          load_ready, accept, launch, finish;
    logic          start_q, done_q;
    logic          b_exhausted, m_exhausted;

    assign load_ready       = (state == EMPTY) || (state == FILL);
    assign accept           = bus.load_valid_i && load_ready;
    assign bus.load_ready_o = load_ready;
    assign bus.full_o       = (state == FULL);
    assign bus.start_o      = start_q;
    assign bus.done_o       = done_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            EMPTY, FILL: begin
                if (accept) state_next = (wr_cnt == PW'(S - 1)) ? FULL : FILL;
            end
            FULL: begin
                if (bus.go_i) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (b_exhausted && m_exhausted) begin
                    finish     = 1'b1;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= EMPTY;
            wr_cnt  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= launch;
            done_q  <= finish;
            if (finish)      wr_cnt <= '0;
            else if (accept) wr_cnt <= wr_cnt + PW'(1);
        end
    end

    amns_slice_buffer #(.WIDTH(DW), .S(S), .PW(PW)) u_b_buf (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_en     (accept),
        .wr_addr   (wr_cnt),
        .wr_data   (bus.load_B_i),
        .launch    (launch),
        .shift     (bus.B_shift_i && (state == RUN)),
        .flush     (finish),
        .dout      (bus.B_dout_o),
        .exhausted (b_exhausted)
    );

    amns_slice_buffer #(.WIDTH(DW), .S(S), .PW(PW)) u_m_buf (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_en     (accept),
        .wr_addr   (wr_cnt),
        .wr_data   (bus.load_M_i),
        .launch    (launch),
        .shift     (bus.M_shift_i && (state == RUN)),
        .flush     (finish),
        .dout      (bus.M_dout_o),
        .exhausted (m_exhausted)
    );
endmodule
